// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic array.
//
// Contents:
//   ctrl_state_t   - sequencer state encoding (IDLE, CLEAR, COMPUTE, DRAIN, DONE)
//   compute_cycles - number of COMPUTE cycles needed for inner dimension k on
//                    an n x n array. Operands are skewed by up to n-1 cycles on
//                    each side, so the last product reaches PE[n-1][n-1] after
//                    k + 2n - 2 cycles. The skew buffers size their depth from
//                    this function too.
package systolic_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StClear   = 3'd1,
        StCompute = 3'd2,
        StDrain   = 3'd3,
        StDone    = 3'd4
    } ctrl_state_t;

    function automatic int unsigned compute_cycles(input int unsigned k, input int unsigned n);
        return k + 2 * n - 2;
    endfunction

endpackage

// File: rtl/tc_counter.sv
// Loadable up-counter with clear, enable and terminal-count compare.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clear       - force count to zero (highest priority after reset)
//   load        - load load_val
//   load_val    - value to load
//   en          - count up by one; saturates at all-ones instead of wrapping
//   last        - terminal value to compare against
//   count       - current count
//   tc          - high while count == last
module tc_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;
    assign tc    = (count_q == last);

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Sequencer for the N x N output-stationary systolic array.
//
// Runs num_tiles output tiles per job. For every tile it clears the
// accumulators (CLEAR, one cycle), feeds the skewed operands for
// k_len + 2N - 2 cycles (COMPUTE), then drains the N result rows over a
// ready/valid port (DRAIN). A final DONE cycle pulses done.
//
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   start        - job request, only looked at in IDLE
//   k_len        - inner dimension, legal range 1..K_MAX, latched on start
//   num_tiles    - tiles per job, must be nonzero, latched on start
//   abort        - cancel the running job (ignored in IDLE and DONE)
//   out_ready    - downstream accepts the presented drain row
//   busy         - any state other than IDLE
//   clear_acc    - accumulator clear, one cycle per tile
//   valid_en     - array enable / operand feed strobe during COMPUTE
//   feed_cnt     - cycle index within COMPUTE
//   tile_idx     - current tile index
//   drain_valid  - drain_row is presented
//   drain_row    - row being drained
//   done         - one-cycle pulse, job finished normally
//   aborted      - one-cycle pulse in the first IDLE cycle after an abort
//   cfg_err      - one-cycle pulse after a rejected start
module systolic_tile_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned K_MAX  = 64,
    parameter int unsigned TILE_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(K_MAX+1)-1:0]   k_len,
    input  logic [TILE_W-1:0]            num_tiles,
    input  logic                         abort,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         clear_acc,
    output logic                         valid_en,
    output logic [$clog2(K_MAX+2*N)-1:0] feed_cnt,
    output logic [TILE_W-1:0]            tile_idx,
    output logic                         drain_valid,
    output logic [$clog2(N)-1:0]         drain_row,
    output logic                         done,
    output logic                         aborted,
    output logic                         cfg_err
);

    localparam int unsigned FW = $clog2(K_MAX + 2 * N);
    localparam int unsigned RW = $clog2(N);

    ctrl_state_t       state_q;
    logic [FW-1:0]     feed_last_q;
    logic [TILE_W-1:0] num_tiles_q;
    logic              aborted_q;
    logic              cfg_err_q;

    logic              cfg_ok;
    logic              abort_act;
    logic              row_hs;
    logic              feed_tc;
    logic              row_tc;
    logic              tile_tc;
    logic              feed_clear;
    logic              feed_en;
    logic              row_clear;
    logic              tile_clear;
    logic              tile_en;
    logic [TILE_W-1:0] tile_last;

    // Legal job: 1 <= k_len <= K_MAX and at least one tile.
    assign cfg_ok = (k_len != '0) && (32'(k_len) <= K_MAX) && (num_tiles != '0);

    // Abort only acts while a tile is in flight; DONE always completes.
    assign abort_act = abort &&
                       ((state_q == StClear) || (state_q == StCompute) || (state_q == StDrain));

    assign row_hs    = (state_q == StDrain) && out_ready;
    assign tile_last = num_tiles_q - TILE_W'(1);

    // Counter controls. Each counter is cleared on the cycle its phase ends so
    // it already reads zero when the phase is next entered.
    always_comb begin
        feed_clear = 1'b1;
        feed_en    = 1'b0;
        row_clear  = 1'b1;
        tile_clear = 1'b0;
        tile_en    = 1'b0;

        if (state_q == StCompute) begin
            feed_en    = 1'b1;
            feed_clear = feed_tc || abort;
        end

        if (state_q == StDrain) begin
            row_clear = abort || (row_hs && row_tc);
        end

        if (state_q == StIdle) begin
            tile_clear = 1'b1;
        end

        if (row_hs && row_tc && !tile_tc && !abort) begin
            tile_en = 1'b1;
        end
    end

    tc_counter #(
        .WIDTH (FW)
    ) u_feed_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (feed_clear),
        .load     (1'b0),
        .load_val ({FW{1'b0}}),
        .en       (feed_en),
        .last     (feed_last_q),
        .count    (feed_cnt),
        .tc       (feed_tc)
    );

    tc_counter #(
        .WIDTH (RW)
    ) u_drain_row (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (row_clear),
        .load     (1'b0),
        .load_val ({RW{1'b0}}),
        .en       (row_hs),
        .last     (RW'(N - 1)),
        .count    (drain_row),
        .tc       (row_tc)
    );

    tc_counter #(
        .WIDTH (TILE_W)
    ) u_tile_idx (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (tile_clear),
        .load     (1'b0),
        .load_val ({TILE_W{1'b0}}),
        .en       (tile_en),
        .last     (tile_last),
        .count    (tile_idx),
        .tc       (tile_tc)
    );

    // Sequencer state, latched job config and the two pulse flags that are
    // reported in the IDLE cycle following their cause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            feed_last_q <= '0;
            num_tiles_q <= '0;
            aborted_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            cfg_err_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_ok) begin
                            // Store C-1 so the compare needs no adder.
                            feed_last_q <= FW'(compute_cycles(32'(k_len), N) - 1);
                            num_tiles_q <= num_tiles;
                            state_q     <= StClear;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end

                StClear: begin
                    if (abort_act) begin
                        state_q   <= StIdle;
                        aborted_q <= 1'b1;
                    end else begin
                        state_q <= StCompute;
                    end
                end

                StCompute: begin
                    if (abort_act) begin
                        state_q   <= StIdle;
                        aborted_q <= 1'b1;
                    end else if (feed_tc) begin
                        state_q <= StDrain;
                    end
                end

                StDrain: begin
                    if (abort_act) begin
                        state_q   <= StIdle;
                        aborted_q <= 1'b1;
                    end else if (row_hs && row_tc) begin
                        state_q <= tile_tc ? StDone : StClear;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy        = (state_q != StIdle);
    assign clear_acc   = (state_q == StClear);
    assign valid_en    = (state_q == StCompute);
    assign drain_valid = (state_q == StDrain);
    assign done        = (state_q == StDone);
    assign aborted     = aborted_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Scoreboard bench for systolic_tile_ctrl. A job-level reference model turns
// each issued job into a list of expected per-cycle observations; a monitor
// compares every cycle against the head of that list.
module tb_systolic_tile_ctrl;

    localparam int N       = 4;
    localparam int K_MAX   = 64;
    localparam int TILE_W  = 8;
    localparam int KW      = $clog2(K_MAX + 1);
    localparam int FW      = $clog2(K_MAX + 2 * N);
    localparam int RW      = $clog2(N);
    localparam int RDY_LEN = 16384;

    // Event bits: {cfg_err, aborted, done, drain_valid, valid_en, clear_acc}
    localparam int EvClr  = 1;
    localparam int EvVal  = 2;
    localparam int EvDv   = 4;
    localparam int EvDone = 8;
    localparam int EvAbt  = 16;
    localparam int EvCfg  = 32;

    typedef struct {
        int cyc;
        int ev;
        int busy;
        int tile;
        int feed;
        int row;
        bit ct;
        bit cf;
        bit cr;
    } rec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [KW-1:0]     k_len;
    logic [TILE_W-1:0] num_tiles;
    logic              abort;
    logic              out_ready;
    logic              busy;
    logic              clear_acc;
    logic              valid_en;
    logic [FW-1:0]     feed_cnt;
    logic [TILE_W-1:0] tile_idx;
    logic              drain_valid;
    logic [RW-1:0]     drain_row;
    logic              done;
    logic              aborted;
    logic              cfg_err;

    int   cyc;
    int   checks;
    int   failures;
    bit   mon_on;
    bit   rdy[RDY_LEN];
    rec_t sb[$];

    systolic_tile_ctrl #(
        .N      (N),
        .K_MAX  (K_MAX),
        .TILE_W (TILE_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .k_len       (k_len),
        .num_tiles   (num_tiles),
        .abort       (abort),
        .out_ready   (out_ready),
        .busy        (busy),
        .clear_acc   (clear_acc),
        .valid_en    (valid_en),
        .feed_cnt    (feed_cnt),
        .tile_idx    (tile_idx),
        .drain_valid (drain_valid),
        .drain_row   (drain_row),
        .done        (done),
        .aborted     (aborted),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic rec_t mk(input int c, input int ev, input int bsy, input int tile,
                                input int feed, input int row, input bit ct, input bit cf,
                                input bit cr);
        rec_t r;
        r.cyc  = c;
        r.ev   = ev;
        r.busy = bsy;
        r.tile = tile;
        r.feed = feed;
        r.row  = row;
        r.ct   = ct;
        r.cf   = cf;
        r.cr   = cr;
        return r;
    endfunction

    // Reference model: expected observations for a job whose start is
    // presented in cycle s. ab / rs are the abort / reset cycles (-1 = none).
    // fin is the first cycle in which the controller is idle again.
    task automatic model_job(input int s, input int k, input int nt, input int ab,
                             input int rs, output int fin);
        rec_t l[$];
        int   t;
        int   c;
        int   done_c;
        bit   hs;
        if (k < 1 || k > K_MAX || nt < 1) begin
            sb.push_back(mk(s + 1, EvCfg, 0, 0, 0, 0, 0, 0, 0));
            fin = s + 1;
            return;
        end
        c = k + 2 * N - 2;
        t = s + 1;
        for (int tile = 0; tile < nt; tile++) begin
            l.push_back(mk(t, EvClr, 1, tile, 0, 0, 1, 1, 0));
            t++;
            for (int f = 0; f < c; f++) begin
                l.push_back(mk(t, EvVal, 1, tile, f, 0, 1, 1, 0));
                t++;
            end
            for (int row = 0; row < N; row++) begin
                do begin
                    l.push_back(mk(t, EvDv, 1, tile, 0, row, 1, 0, 1));
                    hs = rdy[t];
                    t++;
                end while (!hs);
            end
        end
        done_c = t;
        l.push_back(mk(done_c, EvDone, 1, 0, 0, 0, 0, 0, 0));
        fin = done_c + 1;
        if (rs > s && rs <= done_c) begin
            foreach (l[i]) if (l[i].cyc <= rs) sb.push_back(l[i]);
            sb.push_back(mk(rs + 1, 0, 0, 0, 0, 0, 1, 1, 1));
            fin = rs + 1;
        end else if (ab > s && ab < done_c) begin
            foreach (l[i]) if (l[i].cyc <= ab) sb.push_back(l[i]);
            sb.push_back(mk(ab + 1, EvAbt, 0, 0, 0, 0, 0, 0, 0));
            fin = ab + 1;
        end else begin
            foreach (l[i]) sb.push_back(l[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= RDY_LEN - 400) begin
            failures++;
            $display("FAIL cycle_budget cycle=%0d got=%0d expected<%0d", cyc, cyc, RDY_LEN - 400);
            $fatal(1, "cycle budget exhausted");
        end
        out_ready = rdy[cyc];
    endtask

    task automatic run_job(input int k, input int nt, input int gap, input int ab_off,
                           input int rs_off, input bit force_rdy, input int stall_off,
                           input int stall_len);
        int s;
        int fin;
        int ab;
        int rs;
        s = cyc + gap;
        if (force_rdy) begin
            for (int i = s; i < s + 300 && i < RDY_LEN; i++) rdy[i] = 1'b1;
        end
        for (int i = 0; i < stall_len; i++) rdy[s + stall_off + i] = 1'b0;
        out_ready = rdy[cyc];
        ab = (ab_off < 0) ? -1 : s + ab_off;
        rs = (rs_off < 0) ? -1 : s + rs_off;
        model_job(s, k, nt, ab, rs, fin);
        while (cyc < fin) begin
            start = 1'b0;
            abort = 1'b0;
            rst_n = 1'b1;
            if (cyc == s) begin
                start     = 1'b1;
                k_len     = KW'(k);
                num_tiles = TILE_W'(nt);
            end else if (cyc > s) begin
                // Stray starts and config changes while busy must be ignored.
                start     = ($urandom_range(0, 3) == 0);
                k_len     = KW'($urandom);
                num_tiles = TILE_W'($urandom);
            end else begin
                abort = ($urandom_range(0, 3) == 0);
            end
            if (cyc == ab) abort = 1'b1;
            if (cyc == rs) rst_n = 1'b0;
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
    endtask

    // Monitor: one expected record per active cycle; quiet cycles must be idle.
    always @(negedge clk) begin : monitor
        logic [5:0] ev;
        rec_t       r;
        if (mon_on && cyc >= 1) begin
            ev = {cfg_err, aborted, done, drain_valid, valid_en, clear_acc};
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                r = sb.pop_front();
                chk("missed_record", cyc, r.cyc);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                r = sb.pop_front();
                chk("events", int'(ev), r.ev);
                chk("busy", int'(busy), r.busy);
                if (r.ct) chk("tile_idx", int'(tile_idx), r.tile);
                if (r.cf) chk("feed_cnt", int'(feed_cnt), r.feed);
                if (r.cr) chk("drain_row", int'(drain_row), r.row);
            end else begin
                chk("quiet", int'({busy, ev}), 0);
            end
        end
    end

    initial begin
        int k;
        int nt;
        int ab;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        mon_on    = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        k_len     = '0;
        num_tiles = '0;
        for (int i = 0; i < RDY_LEN; i++) rdy[i] = ($urandom_range(0, 3) != 0);
        out_ready = rdy[0];
        // Reset values in the two cycles following the reset edges.
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 1));
        sb.push_back(mk(2, 0, 0, 0, 0, 0, 1, 1, 1));
        mon_on = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        // Single tile, k=4, full throughput.
        run_job(4, 1, 0, -1, -1, 1'b1, 0, 0);
        // Three tiles, k=3, back to back with the previous job.
        run_job(3, 3, 0, -1, -1, 1'b1, 0, 0);
        // Five-cycle stall while row 2 is presented.
        run_job(4, 1, 1, -1, -1, 1'b1, 14, 5);
        // Rejected configurations.
        run_job(0, 1, 0, -1, -1, 1'b0, 0, 0);
        run_job(K_MAX + 1, 1, 0, -1, -1, 1'b0, 0, 0);
        run_job(5, 0, 0, -1, -1, 1'b0, 0, 0);
        // Abort in COMPUTE at feed_cnt=3.
        run_job(4, 1, 2, 5, -1, 1'b1, 0, 0);
        // Abort raised in DONE is ignored.
        run_job(2, 1, 0, 14, -1, 1'b1, 0, 0);
        // Reset while draining tile 1, then a clean job.
        run_job(3, 3, 1, -1, 26, 1'b1, 0, 0);
        run_job(4, 2, 0, -1, -1, 1'b0, 0, 0);
        // Largest inner dimension.
        run_job(K_MAX, 1, 0, -1, -1, 1'b0, 0, 0);

        for (int j = 0; j < 30; j++) begin
            k  = $urandom_range(1, 20);
            nt = $urandom_range(1, 3);
            if ($urandom_range(0, 7) == 0) k = K_MAX;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0:       k = 0;
                    1:       k = $urandom_range(K_MAX + 1, (1 << KW) - 1);
                    default: nt = 0;
                endcase
            end
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 80) : -1;
            run_job(k, nt, $urandom_range(0, 3), ab, -1, 1'b0, 0, 0);
        end

        for (int i = 0; i < 4; i++) step();
        mon_on = 1'b0;
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
